// File: rtl/spi_burst_master_if.sv
// spi_burst_master_if: host-side word handshake and status for spi_burst_master
interface spi_burst_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS = 4
);
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  trigger_in;
  logic                  last_in;
  logic [CSW-1:0]        cs_idx_in;
  logic                  cpol_in;
  logic                  cpha_in;
  logic                  ready_out;
  logic                  busy_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid_out;
  modport master (
    output data_in, trigger_in, last_in, cs_idx_in, cpol_in, cpha_in,
    input  ready_out, busy_out, data_out, data_valid_out
  );
  modport slave (
    input  data_in, trigger_in, last_in, cs_idx_in, cpol_in, cpha_in,
    output ready_out, busy_out, data_out, data_valid_out
  );
endinterface

// File: rtl/spi_burst_master.sv
// spi_burst_master: multi-word SPI master, all CPOL/CPHA modes, one-hot active-low CS; define SPI_LSB_FIRST_EN for LSB-first bursts
module spi_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_CLK_PERIOD = 100,
  parameter int NUM_CS = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  spi_burst_master_if.slave bus,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first_in,
`endif
  output logic              chip_data_out,
  input  logic              chip_data_in,
  output logic              chip_clk_out,
  output logic [NUM_CS-1:0] chip_sel_out
);
  localparam int H = DATA_CLK_PERIOD < 4 ? 1 : DATA_CLK_PERIOD / 2;
  localparam int HW = $clog2(H + 1);
  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, GAP} state_t;
  state_t                state_q, state_d;
  logic [HW-1:0]         cnt_q, cnt_d;
  logic [EW-1:0]         edg_q, edg_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic [NUM_CS-1:0]     cs_q, cs_d, cs_sel;
  logic dv_q, dv_d, cop_q, cop_d, sclk_q, sclk_d, last_q, last_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  logic first, accept, tick, lead, final_edge, pha, lsb_new, lsb_cur, lsb_sel;

  function automatic logic pick(input logic [DATA_WIDTH-1:0] v, input logic l);
    return l ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] adv(input logic [DATA_WIDTH-1:0] v, input logic l);
    return l ? v >> 1 : v << 1;
  endfunction

`ifdef SPI_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_new = lsb_first_in;
  assign lsb_cur = lsb_q;
  assign lsb_d = first && accept ? lsb_first_in : lsb_q;
  // Bit order is fixed for the whole burst by its first word
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) lsb_q <= 1'b0;
    else lsb_q <= lsb_d;
`else
  assign lsb_new = 1'b0;
  assign lsb_cur = 1'b0;
`endif

  assign first = state_q == IDLE;
  assign accept = bus.trigger_in && bus.ready_out;
  assign tick = cnt_q == HW'(H - 1);
  assign lead = sclk_q == cpol_q;
  assign final_edge = edg_q == EW'(2 * DATA_WIDTH - 1);
  assign pha = first ? bus.cpha_in : cpha_q;
  assign lsb_sel = first ? lsb_new : lsb_cur;
  assign cs_sel = {1'b0, bus.cs_idx_in} < (CSW + 1)'(NUM_CS) ? ~(NUM_CS'(1) << bus.cs_idx_in) : '1;

  // Next-state: word accept in IDLE/WAIT, half-period pacing, edge-driven shift and sample
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    edg_d = edg_q;
    tx_d = tx_q;
    rx_d = rx_q;
    dout_d = dout_q;
    dv_d = 1'b0;
    cop_d = cop_q;
    sclk_d = sclk_q;
    cs_d = cs_q;
    last_d = last_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    if (accept) begin
      state_d = SETUP;
      cnt_d = '0;
      edg_d = '0;
      last_d = bus.last_in;
      tx_d = pha ? bus.data_in : adv(bus.data_in, lsb_sel);
      cop_d = pha ? cop_q : pick(bus.data_in, lsb_sel);
      if (first) begin
        cpol_d = bus.cpol_in;
        cpha_d = bus.cpha_in;
        sclk_d = bus.cpol_in;
        cs_d = cs_sel;
      end
    end
    if (state_q == SETUP || state_q == GAP) begin
      cnt_d = tick ? '0 : cnt_q + HW'(1);
      if (tick) state_d = state_q == GAP ? IDLE : SHIFT;
    end
    if (state_q == SHIFT) begin
      cnt_d = tick ? '0 : cnt_q + HW'(1);
      if (tick) begin
        sclk_d = ~sclk_q;
        edg_d = edg_q + EW'(1);
        if (lead ^ cpha_q)
          rx_d = lsb_cur ? {chip_data_in, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], chip_data_in};
        else if (!final_edge) begin
          cop_d = pick(tx_q, lsb_cur);
          tx_d = adv(tx_q, lsb_cur);
        end
        if (final_edge) begin
          state_d = last_q ? GAP : WAIT;
          dout_d = rx_d;
          dv_d = 1'b1;
          edg_d = '0;
          cs_d = last_q ? '1 : cs_q;
        end
      end
    end
  end

  // State and datapath registers; reset drops every line to its idle level at once
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      edg_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      dout_q <= '0;
      dv_q <= 1'b0;
      cop_q <= 1'b0;
      sclk_q <= 1'b0;
      cs_q <= '1;
      last_q <= 1'b0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      edg_q <= edg_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      dout_q <= dout_d;
      dv_q <= dv_d;
      cop_q <= cop_d;
      sclk_q <= sclk_d;
      cs_q <= cs_d;
      last_q <= last_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
    end

  assign bus.ready_out = !rst_in && (state_q == IDLE || state_q == WAIT);
  assign bus.busy_out = !rst_in && state_q != IDLE;
  assign bus.data_out = dout_q;
  assign bus.data_valid_out = dv_q;
  assign chip_data_out = cop_q;
  assign chip_clk_out = sclk_q;
  assign chip_sel_out = cs_q;
endmodule
